ddr_cmd_sched: RTL and testbench

DDR_CMD_SCHED -- requirements
Module: ddr_cmd_sched

---
 rtl/ddr_package.sv | 42 ++++
 rtl/ddr_rr_arbiter.sv | 33 +++
 rtl/ddr_cmd_sched.sv | 254 +++++++++++++++++++++++++
 tb/tb_ddr_cmd_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_package.sv
// ddr_package: command, address and scheduler-state types shared by the
// DDR command scheduler and its testbench.
// The REF/RFC_WAIT states exist only when DDR_SCHED_REFRESH_EN is defined.
package ddr_package;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } ddr_cmd_t;

    typedef struct packed {
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [16:0] row;
        logic [9:0]  col;
    } ddr_addr_t;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ACT        = 4'd1,
        ST_RCD_WAIT   = 4'd2,
        ST_CAS        = 4'd3,
        ST_BURST_WAIT = 4'd4,
        ST_PRE        = 4'd5,
        ST_RP_WAIT    = 4'd6
`ifdef DDR_SCHED_REFRESH_EN
        ,
        ST_REF        = 4'd7,
        ST_RFC_WAIT   = 4'd8
`endif
    } sched_state_t;

    // Column command for a latched access direction (1 = write).
    function automatic ddr_cmd_t cas_cmd(input logic rw);
        return rw ? CMD_WR : CMD_RD;
    endfunction

endpackage

// File: rtl/ddr_rr_arbiter.sv
// ddr_rr_arbiter: rotating-priority arbiter. Searches the request vector
// from ptr_i upward with wrap-around and returns a one-hot winner.
module ddr_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               valid_o
);

    int               slot_s;
    logic [PTR_W-1:0] slot_idx_s;
    logic             hit_s;

    // First asserted request at or above the pointer wins; later hits are masked.
    always_comb begin
        gnt_o      = '0;
        valid_o    = 1'b0;
        slot_s     = 0;
        slot_idx_s = '0;
        hit_s      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_s             = (int'(ptr_i) + i) % NUM_REQ;
            slot_idx_s         = slot_s[PTR_W-1:0];
            hit_s              = req_i[slot_idx_s] & ~valid_o;
            gnt_o[slot_idx_s]  = gnt_o[slot_idx_s] | hit_s;
            valid_o            = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched: single-access DDR command scheduler. Grants one requester
// round-robin, then issues ACT -> RD/WR -> PRE with fixed T_RCD/T_BURST/T_RP
// spacing before returning to IDLE.
// Define DDR_SCHED_REFRESH_EN to add periodic REF with T_REFI/T_RFC timing.
module ddr_cmd_sched
    import ddr_package::*;
#(
    parameter int NUM_REQ = 4,
    parameter int T_RCD   = 4,
    parameter int T_BURST = 4,
    parameter int T_RP    = 3,
    parameter int T_REFI  = 64,
    parameter int T_RFC   = 8
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_rw_i,
    input  ddr_addr_t [NUM_REQ-1:0]   req_addr_i,
    input  logic                      dev_busy_i,
    output logic [NUM_REQ-1:0]        req_gnt_o,
    output logic                      cmd_valid_o,
    output ddr_cmd_t                  cmd_type_o,
    output ddr_addr_t                 cmd_addr_o,
    output logic                      sched_busy_o
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int MAX_AB  = (T_RCD > T_BURST) ? T_RCD : T_BURST;
    localparam int MAX_ABC = (MAX_AB > T_RP) ? MAX_AB : T_RP;
    localparam int CNT_MAX = (MAX_ABC > T_RFC) ? MAX_ABC : T_RFC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    // Wait states hold for (interval - 1) cycles, so the counter loads interval - 2.
    localparam logic [CNT_W-1:0] RCD_LOAD   = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(T_BURST - 2);
    localparam logic [CNT_W-1:0] RP_LOAD    = CNT_W'(T_RP - 2);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    ddr_addr_t        cmd_addr_q, cmd_addr_d;
    logic             cmd_valid_q, cmd_valid_d;
    ddr_cmd_t         cmd_type_q, cmd_type_d;
    logic             sched_busy_q, sched_busy_d;

    logic [NUM_REQ-1:0] arb_gnt_s;
    logic               arb_valid_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic [PTR_W-1:0]   next_ptr_s;
    logic               grant_s;

    ddr_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt_s),
        .valid_o (arb_valid_s)
    );

    // Encode the one-hot winner and compute the pointer that follows it.
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx_s = win_idx_s | (arb_gnt_s[i] ? PTR_W'(i) : '0);
        end
        next_ptr_s = (win_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_s + PTR_W'(1);
    end

`ifdef DDR_SCHED_REFRESH_EN
    localparam int                REFI_W    = $clog2(T_REFI);
    localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI - 1);
    localparam logic [CNT_W-1:0]  RFC_LOAD  = CNT_W'(T_RFC - 2);

    logic [REFI_W-1:0] ref_cnt_q, ref_cnt_d;
    logic              ref_pending_q, ref_pending_d;
    logic              ref_expire_s;
    logic              ref_clr_s;

    // Free-running refresh interval timer; an expiry while pending is absorbed.
    always_comb begin
        ref_expire_s = (ref_cnt_q == REFI_LAST);
        if (ref_expire_s) begin
            ref_cnt_d = '0;
        end else begin
            ref_cnt_d = ref_cnt_q + REFI_W'(1);
        end
        ref_pending_d = ref_expire_s | (ref_pending_q & ~ref_clr_s);
    end

    // Refresh timer and pending-flag registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
        end else begin
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
        end
    end
`else
    // Refresh interval has no effect when refresh support is not built.
    logic unused_refresh_s;
    assign unused_refresh_s = ^T_REFI;
`endif

    // Next-state logic: arbitration in IDLE, fixed-length command sequence otherwise.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        cmd_addr_d = cmd_addr_q;
        grant_s    = 1'b0;
`ifdef DDR_SCHED_REFRESH_EN
        ref_clr_s  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef DDR_SCHED_REFRESH_EN
                if (ref_pending_q) begin
                    ref_clr_s = 1'b1;
                    state_d   = ST_REF;
                end else
`endif
                if (arb_valid_s && !dev_busy_i) begin
                    grant_s    = 1'b1;
                    state_d    = ST_ACT;
                    ptr_d      = next_ptr_s;
                    rw_d       = req_rw_i[win_idx_s];
                    cmd_addr_d = req_addr_i[win_idx_s];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACT: begin
                state_d = ST_RCD_WAIT;
                cnt_d   = RCD_LOAD;
            end
            ST_RCD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CAS: begin
                state_d = ST_BURST_WAIT;
                cnt_d   = BURST_LOAD;
            end
            ST_BURST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_PRE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PRE: begin
                state_d = ST_RP_WAIT;
                cnt_d   = RP_LOAD;
            end
            ST_RP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef DDR_SCHED_REFRESH_EN
            ST_REF: begin
                state_d = ST_RFC_WAIT;
                cnt_d   = RFC_LOAD;
            end
            ST_RFC_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Command decode from the upcoming state so command outputs can be registered.
    always_comb begin
        cmd_valid_d = 1'b0;
        cmd_type_d  = CMD_NOP;
        case (state_d)
            ST_ACT: begin
                cmd_valid_d = 1'b1;
                cmd_type_d  = CMD_ACT;
            end
            ST_CAS: begin
                cmd_valid_d = 1'b1;
                cmd_type_d  = cas_cmd(rw_d);
            end
            ST_PRE: begin
                cmd_valid_d = 1'b1;
                cmd_type_d  = CMD_PRE;
            end
`ifdef DDR_SCHED_REFRESH_EN
            ST_REF: begin
                cmd_valid_d = 1'b1;
                cmd_type_d  = CMD_REF;
            end
`endif
            default: begin
                cmd_valid_d = 1'b0;
                cmd_type_d  = CMD_NOP;
            end
        endcase
        sched_busy_d = (state_d != ST_IDLE);
    end

    // State, timing counter, arbitration pointer, latched access and output registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            rw_q         <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_type_q   <= CMD_NOP;
            sched_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            rw_q         <= rw_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_type_q   <= cmd_type_d;
            sched_busy_q <= sched_busy_d;
        end
    end

    // The grant pulse must coincide with the IDLE cycle that accepts the request,
    // so it is driven from the arbiter directly and held low while in reset.
    assign req_gnt_o    = (grant_s && !reset_i) ? arb_gnt_s : '0;
    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_type_o   = cmd_type_q;
    assign cmd_addr_o   = cmd_addr_q;
    assign sched_busy_o = sched_busy_q;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// tb_ddr_cmd_sched: directed timing scenarios plus a randomized run checked
// against a timeline model (grant time -> command offsets) of the scheduler.
module tb_ddr_cmd_sched;
    import ddr_package::*;

    localparam int NREQ   = 4;
    localparam int TRCD   = 4;
    localparam int TBURST = 4;
    localparam int TRP    = 3;
    localparam int OP_LEN = 1 + TRCD + TBURST + TRP;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_rw;
    ddr_addr_t [NREQ-1:0]   req_addr;
    logic                   dev_busy;
    logic [NREQ-1:0]        req_gnt;
    logic                   cmd_valid;
    ddr_cmd_t               cmd_type;
    ddr_addr_t              cmd_addr;
    logic                   sched_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ddr_cmd_sched #(
        .NUM_REQ (NREQ),
        .T_RCD   (TRCD),
        .T_BURST (TBURST),
        .T_RP    (TRP),
        .T_REFI  (64),
        .T_RFC   (8)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .req_valid_i  (req_valid),
        .req_rw_i     (req_rw),
        .req_addr_i   (req_addr),
        .dev_busy_i   (dev_busy),
        .req_gnt_o    (req_gnt),
        .cmd_valid_o  (cmd_valid),
        .cmd_type_o   (cmd_type),
        .cmd_addr_o   (cmd_addr),
        .sched_busy_o (sched_busy)
    );

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        dev_busy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        req_rw = '0;
        req_addr = '0;
        dev_busy = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (req_gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", req_gnt); end
        n_tests++;
        if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
        n_tests++;
        if (cmd_type !== CMD_NOP) begin n_fail++; $display("FAIL reset_cmd_type: got %0d expected %0d", cmd_type, CMD_NOP); end
        n_tests++;
        if (cmd_addr !== 31'd0) begin n_fail++; $display("FAIL reset_cmd_addr: got %h expected 0", cmd_addr); end
        n_tests++;
        if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", sched_busy); end
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (sched_busy !== 1'b0 || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_after_release: busy %b valid %b expected 0 0", sched_busy, cmd_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        ddr_addr_t a, act_addr;
        int n_gnt, t_act, t_wr, t_pre, t_idle, n_cmd;
        apply_reset();
        a = '0;
        a.row = 17'h00010;
        a.col = 10'h02;
        req_valid = 4'b0100;
        req_rw = 4'b0100;
        req_addr[2] = a;
        n_gnt = -1; t_act = -1; t_wr = -1; t_pre = -1; t_idle = -1; n_cmd = 0; act_addr = '0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_gnt === 4'b0100 && n_gnt < 0) n_gnt = t;
            if (cmd_valid === 1'b1) begin
                n_cmd++;
                if (cmd_type == CMD_ACT) begin t_act = t; act_addr = cmd_addr; end
                else if (cmd_type == CMD_WR) t_wr = t;
                else if (cmd_type == CMD_PRE) t_pre = t;
            end
            if (n_gnt >= 0 && t > n_gnt && t_idle < 0 && sched_busy === 1'b0) t_idle = t;
            @(posedge clk);
            #1;
            if (n_gnt >= 0) req_valid = '0;
        end
        n_tests++;
        if (n_gnt != 0) begin n_fail++; $display("FAIL single_gnt_cycle: got %0d expected 0", n_gnt); end
        n_tests++;
        if (t_act != 1) begin n_fail++; $display("FAIL single_act_cycle: got %0d expected 1", t_act); end
        n_tests++;
        if (t_wr != 5) begin n_fail++; $display("FAIL single_wr_cycle: got %0d expected 5", t_wr); end
        n_tests++;
        if (t_pre != 9) begin n_fail++; $display("FAIL single_pre_cycle: got %0d expected 9", t_pre); end
        n_tests++;
        if (t_idle != 12) begin n_fail++; $display("FAIL single_idle_cycle: got %0d expected 12", t_idle); end
        n_tests++;
        if (n_cmd != 3) begin n_fail++; $display("FAIL single_cmd_count: got %0d expected 3", n_cmd); end
        n_tests++;
        if (act_addr !== a) begin n_fail++; $display("FAIL single_act_addr: got %h expected %h", act_addr, a); end
    endtask

    task automatic test_round_robin();
        int gidx[$];
        int gcyc[$];
        logic [NREQ-1:0] seen;
        apply_reset();
        for (int i = 0; i < NREQ; i++) req_addr[i] = ddr_addr_t'(31'($urandom));
        req_rw = 4'b1010;
        req_valid = 4'b1111;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            seen = req_gnt;
            if (seen != '0) begin
                n_tests++;
                if (!$onehot(seen)) begin n_fail++; $display("FAIL rr_onehot: got %b expected one-hot", seen); end
                for (int i = 0; i < NREQ; i++) if (seen[i]) begin gidx.push_back(i); gcyc.push_back(t); end
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~seen;
        end
        n_tests++;
        if (gidx.size() != 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 4", gidx.size()); end
        for (int k = 0; k < gidx.size() && k < 4; k++) begin
            n_tests++;
            if (gidx[k] != k) begin n_fail++; $display("FAIL rr_order: grant %0d went to %0d expected %0d", k, gidx[k], k); end
            n_tests++;
            if (gcyc[k] != k * OP_LEN) begin n_fail++; $display("FAIL rr_spacing: grant %0d at %0d expected %0d", k, gcyc[k], k * OP_LEN); end
        end
    endtask

    task automatic test_dev_busy();
        int early;
        apply_reset();
        dev_busy = 1'b1;
        req_valid = 4'b0001;
        req_rw = 4'b0000;
        req_addr[0] = ddr_addr_t'(31'h1234567);
        early = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (req_gnt !== 4'b0000) early++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (early != 0) begin n_fail++; $display("FAIL busy_no_grant: got %0d grant cycles expected 0", early); end
        dev_busy = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_gnt !== 4'b0001) begin n_fail++; $display("FAIL busy_release_grant: got %b expected 0001", req_gnt); end
        @(posedge clk);
        #1;
        req_valid = '0;
        dev_busy = 1'b1;
        repeat (OP_LEN + 2) @(posedge clk);
        #1;
        n_tests++;
        if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL busy_op_completes: busy %b expected 0", sched_busy); end
        dev_busy = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int found, n_cmd, n_busy;
        apply_reset();
        req_valid = 4'b0010;
        req_rw = 4'b0010;
        req_addr[1] = ddr_addr_t'(31'h0ABCDEF);
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1 && cmd_type == CMD_WR) found = 1;
            @(posedge clk);
            #1;
            req_valid = '0;
        end
        n_tests++;
        if (found != 1) begin n_fail++; $display("FAIL midrst_cas_seen: got %0d expected 1", found); end
        rst = 1'b1;
        #1;
        n_tests++;
        if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", sched_busy); end
        n_tests++;
        if (cmd_addr !== 31'd0) begin n_fail++; $display("FAIL midrst_addr: got %h expected 0", cmd_addr); end
        n_tests++;
        if (cmd_valid !== 1'b0 || cmd_type !== CMD_NOP) begin
            n_fail++; $display("FAIL midrst_cmd: valid %b type %0d expected 0 %0d", cmd_valid, cmd_type, CMD_NOP);
        end
        @(negedge clk);
        rst = 1'b0;
        n_cmd = 0; n_busy = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0) n_cmd++;
            if (sched_busy !== 1'b0) n_busy++;
        end
        n_tests++;
        if (n_cmd != 0 || n_busy != 0) begin
            n_fail++; $display("FAIL midrst_no_pre: got %0d commands %0d busy cycles expected 0 0", n_cmd, n_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [NREQ-1:0]      pend, prw, exp_gnt;
        ddr_addr_t [NREQ-1:0] paddr;
        ddr_addr_t            lat;
        logic                 lat_rw, exp_valid, exp_busy;
        ddr_cmd_t             exp_type;
        int g, ptr, off, busy_left, win, c;
        apply_reset();
        pend = '0; prw = '0; paddr = '0; lat = '0; lat_rw = 1'b0;
        g = -1000; ptr = 0; busy_left = 0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 5) == 0) begin
                    pend[i]  = 1'b1;
                    prw[i]   = 1'($urandom_range(0, 1));
                    paddr[i] = ddr_addr_t'(31'($urandom));
                end
            end
            if (busy_left > 0) busy_left--;
            else if ($urandom_range(0, 15) == 0) busy_left = $urandom_range(1, 14);
            dev_busy  = (busy_left > 0);
            req_valid = pend;
            req_rw    = prw;
            req_addr  = paddr;
            @(negedge clk);
            off       = t - g;
            exp_valid = (off == 1) || (off == 1 + TRCD) || (off == 1 + TRCD + TBURST);
            exp_type  = (off == 1) ? CMD_ACT :
                        (off == 1 + TRCD) ? (lat_rw ? CMD_WR : CMD_RD) :
                        (off == 1 + TRCD + TBURST) ? CMD_PRE : CMD_NOP;
            exp_busy  = (off >= 1) && (off < OP_LEN);
            exp_gnt   = '0;
            win       = -1;
            if (off >= OP_LEN && !dev_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (ptr + k) % NREQ;
                    if (win < 0 && pend[c]) win = c;
                end
            end
            if (win >= 0) exp_gnt[win] = 1'b1;
            n_tests++;
            if (req_gnt !== exp_gnt) begin n_fail++; $display("FAIL rand_gnt @%0d: got %b expected %b", t, req_gnt, exp_gnt); end
            n_tests++;
            if (cmd_valid !== exp_valid) begin n_fail++; $display("FAIL rand_cmd_valid @%0d: got %b expected %b", t, cmd_valid, exp_valid); end
            n_tests++;
            if (cmd_type !== exp_type) begin n_fail++; $display("FAIL rand_cmd_type @%0d: got %0d expected %0d", t, cmd_type, exp_type); end
            n_tests++;
            if (cmd_addr !== lat) begin n_fail++; $display("FAIL rand_cmd_addr @%0d: got %h expected %h", t, cmd_addr, lat); end
            n_tests++;
            if (sched_busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy @%0d: got %b expected %b", t, sched_busy, exp_busy); end
            if (win >= 0) begin
                g = t;
                ptr = (win + 1) % NREQ;
                lat = paddr[win];
                lat_rw = prw[win];
                pend[win] = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && $urandom_range(0, 40) == 0) pend[i] = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        dev_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_rw = '0;
        req_addr = '0;
        dev_busy = 1'b0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_dev_busy();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
